// File: rtl/servo_pwm_multi_if.sv
// servo_pwm_multi_if
//   Duty-register write bus between the bus register block and the PWM engine.
//   master: register block (drives the write strobe, channel index and data)
//   slave : servo_pwm_multi (samples them on clk)
// Signals:
//   duty_wr_en   one-cycle write strobe
//   duty_wr_ch   target channel index (CH_W bits)
//   duty_wr_data high time in clocks (CNT_W bits)
interface servo_pwm_multi_if #(
  parameter int CNT_W = 32,
  parameter int CH_W  = 2
);
  logic             duty_wr_en;
  logic [CH_W-1:0]  duty_wr_ch;
  logic [CNT_W-1:0] duty_wr_data;

  modport master (output duty_wr_en, duty_wr_ch, duty_wr_data);
  modport slave  (input  duty_wr_en, duty_wr_ch, duty_wr_data);
endinterface

// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi
//   Multi-channel servo PWM generator. NUM_CH outputs share one period
//   counter; the frame length is reloaded from i_period_value at every frame
//   boundary. Each channel has a pending and an active duty register; pending
//   values move to active all at once on the boundary, so a pulse is never cut
//   or stretched mid-frame.
// Configuration macro:
//   SERVO_CLAMP_EN  when defined, written duty values are saturated to
//                   [DUTY_MIN, DUTY_MAX] before reaching the pending register.
// Ports:
//   i_clk           system clock
//   i_reset         synchronous reset, active high
//   i_enable        1 = run, 0 = hold counter at 0 and drive outputs low
//   i_period_value  frame length in clocks (0/1 treated as 2)
//   i_wr            duty write bus (slave modport)
//   o_pwm_sig       registered PWM outputs, one per channel
//   o_period_tick   registered pulse on the last clock of each frame

// Per-channel double-buffered duty and output compare.
module servo_pwm_ch #(
  parameter int CNT_W      = 32,
  parameter int DUTY_RESET = 15000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_boundary,
  input  logic             i_wr_hit,
  input  logic [CNT_W-1:0] i_wr_val,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_pwm
);
  logic [CNT_W-1:0] r_pend;
  logic [CNT_W-1:0] r_act;
  logic [CNT_W-1:0] w_pend_nxt;
  logic             r_pwm;

  // A write landing in the boundary cycle is forwarded straight into r_act.
  assign w_pend_nxt = i_wr_hit ? i_wr_val : r_pend;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pend <= CNT_W'(DUTY_RESET);
      r_act  <= CNT_W'(DUTY_RESET);
      r_pwm  <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      // While idle, keep active tracking pending so a restart uses fresh values.
      if (!i_enable)       r_act <= r_pend;
      else if (i_boundary) r_act <= w_pend_nxt;
      r_pwm <= i_enable & (i_cnt < r_act);
    end
  end

  assign o_pwm = r_pwm;
endmodule

module servo_pwm_multi #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int CH_W       = 2,
  parameter int DUTY_RESET = 15000,
  parameter int DUTY_MIN   = 5000,
  parameter int DUTY_MAX   = 25000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [CNT_W-1:0]    i_period_value,
  servo_pwm_multi_if.slave    i_wr,
  output logic [NUM_CH-1:0]   o_pwm_sig,
  output logic                o_period_tick
);
`ifdef SERVO_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_period_act;
  logic              r_tick;
  logic [CNT_W-1:0]  w_next_period;
  logic              w_boundary;
  logic [CNT_W-1:0]  w_wr_val;
  logic [NUM_CH-1:0] w_wr_hit;

  // Frames shorter than 2 clocks are not meaningful; 0 and 1 load as 2.
  assign w_next_period = (i_period_value < CNT_W'(2)) ? CNT_W'(2) : i_period_value;
  assign w_boundary    = (r_cnt == r_period_act - CNT_W'(1));

  always_comb begin
    w_wr_val = i_wr.duty_wr_data;
    if (CLAMP_EN) begin
      if (i_wr.duty_wr_data < CNT_W'(DUTY_MIN))      w_wr_val = CNT_W'(DUTY_MIN);
      else if (i_wr.duty_wr_data > CNT_W'(DUTY_MAX)) w_wr_val = CNT_W'(DUTY_MAX);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt        <= '0;
      r_period_act <= w_next_period;
      r_tick       <= 1'b0;
    end else if (!i_enable) begin
      r_cnt        <= '0;
      r_period_act <= w_next_period;
      r_tick       <= 1'b0;
    end else begin
      r_tick <= w_boundary;
      if (w_boundary) begin
        r_cnt        <= '0;
        r_period_act <= w_next_period;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Indices >= NUM_CH have no matching instance, so such writes fall away.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_wr_hit[g] = i_wr.duty_wr_en && (i_wr.duty_wr_ch == CH_W'(g));

    servo_pwm_ch #(
      .CNT_W      (CNT_W),
      .DUTY_RESET (DUTY_RESET)
    ) u_ch (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_enable   (i_enable),
      .i_boundary (w_boundary),
      .i_wr_hit   (w_wr_hit[g]),
      .i_wr_val   (w_wr_val),
      .i_cnt      (r_cnt),
      .o_pwm      (o_pwm_sig[g])
    );
  end

  assign o_period_tick = r_tick;
endmodule

// File: tb/tb_servo_pwm_multi.sv
module tb_servo_pwm_multi;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int CH_W   = 3;
  localparam int DR     = 30;
  localparam int DMIN   = 10;
  localparam int DMAX   = 90;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [CNT_W-1:0]  pv;
  logic [NUM_CH-1:0] pwm;
  logic              tick;

  servo_pwm_multi_if #(.CNT_W(CNT_W), .CH_W(CH_W)) bus ();

  servo_pwm_multi #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W),
    .DUTY_RESET(DR), .DUTY_MIN(DMIN), .DUTY_MAX(DMAX)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_period_value(pv),
    .i_wr(bus.slave), .o_pwm_sig(pwm), .o_period_tick(tick)
  );

  always #5 clk = ~clk;

  // Reference model: position inside frame, frame length, duty buffers.
  longint m_pos, m_per;
  longint m_pend[NUM_CH];
  longint m_act[NUM_CH];
  logic [NUM_CH:0] exp_q[$];
  int n_chk = 0, n_pass = 0;
  bit done = 0;

  function automatic longint per_of(longint v);
    return (v < 2) ? 2 : v;
  endfunction

  function automatic longint wval(longint d);
`ifdef SERVO_CLAMP_EN
    if (d < DMIN) return DMIN;
    if (d > DMAX) return DMAX;
`endif
    return d;
  endfunction

  // Predict the outputs visible after the coming clock edge and advance state.
  task automatic model_cycle();
    logic [NUM_CH:0] e;
    bit wr;
    e  = '0;
    wr = bus.duty_wr_en && (int'(bus.duty_wr_ch) < NUM_CH);
    if (rst) begin
      m_pos = 0; m_per = per_of(longint'(pv));
      for (int i = 0; i < NUM_CH; i++) begin m_pend[i] = DR; m_act[i] = DR; end
    end else if (!en) begin
      for (int i = 0; i < NUM_CH; i++) m_act[i] = m_pend[i];
      if (wr) m_pend[bus.duty_wr_ch] = wval(longint'(bus.duty_wr_data));
      m_pos = 0; m_per = per_of(longint'(pv));
    end else begin
      for (int i = 0; i < NUM_CH; i++) e[i] = (m_pos < m_act[i]);
      e[NUM_CH] = (m_pos == m_per - 1);
      if (wr) m_pend[bus.duty_wr_ch] = wval(longint'(bus.duty_wr_data));
      if (m_pos == m_per - 1) begin
        for (int i = 0; i < NUM_CH; i++) m_act[i] = m_pend[i];
        m_per = per_of(longint'(pv));
        m_pos = 0;
      end else m_pos++;
    end
    exp_q.push_back(e);
  endtask

  task automatic step(int n = 1);
    for (int k = 0; k < n; k++) begin
      model_cycle();
      @(negedge clk);
    end
  endtask

  task automatic wr(int ch, int d);
    bus.duty_wr_en = 1'b1; bus.duty_wr_ch = CH_W'(ch); bus.duty_wr_data = CNT_W'(d);
    step();
    bus.duty_wr_en = 1'b0;
  endtask

  task automatic until_pos(longint p);
    for (int k = 0; k < 2000 && m_pos != p; k++) step();
  endtask

  // Monitor: pops one prediction per clock and compares.
  initial begin
    logic [NUM_CH:0] e;
    forever begin
      @(posedge clk); #1;
      if (done) break;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_chk++;
        if (pwm === e[NUM_CH-1:0]) n_pass++;
        else $display("FAIL pwm_sig t=%0t got=%b want=%b", $time, pwm, e[NUM_CH-1:0]);
        n_chk++;
        if (tick === e[NUM_CH]) n_pass++;
        else $display("FAIL period_tick t=%0t got=%b want=%b", $time, tick, e[NUM_CH]);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; pv = 100;
    bus.duty_wr_en = 1'b0; bus.duty_wr_ch = '0; bus.duty_wr_data = '0;
    @(negedge clk);
    step(3);
    rst = 1'b0;
    step(250);                       // idle frames at DUTY_RESET
    until_pos(10); wr(1, 50); step(200);   // double buffer
    until_pos(99); wr(2, 70); step(150);   // boundary forwarding
    until_pos(30); pv = 60; step(200);     // mid-frame period change
    pv = 100; wr(0, 0); wr(3, 100); step(250); // constant low / high
    pv = 0; step(40); pv = 100; step(120);     // 2-clock frames
    wr(5, 77); wr(7, 1); step(120);            // out-of-range channel
    pv = 90; wr(1, 5); wr(2, 95); step(300);   // clamp edges
    until_pos(40); en = 1'b0; step(6); wr(0, 20); step(3); en = 1'b1; step(150);
    until_pos(40); rst = 1'b1; step(); rst = 1'b0; step(200);
    // Randomised phase with short frames.
    pv = 25; step(120);
    for (int k = 0; k < 3000; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 15) begin
        bus.duty_wr_en = 1'b1;
        bus.duty_wr_ch = CH_W'($urandom_range(0, 7));
        bus.duty_wr_data = CNT_W'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 200 : 45));
      end else if (r < 18) pv = CNT_W'($urandom_range(0, 40));
      else if (r < 20) en = ~en;
      else if (r == 20 && $urandom_range(0, 4) == 0) rst = 1'b1;
      step();
      bus.duty_wr_en = 1'b0; rst = 1'b0;
      if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
    end
    en = 1'b1; step(50);
    done = 1'b1;
    @(posedge clk); #2;
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
